// File: rtl/wb_read_mux_pkg.sv
// Shared types and constants for the Wishbone read-data return path.
// State encoding, counter widths and the timeout limit helper.
package wb_read_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_ERR
  } state_e;

  // Wait-state counter width (MEM_WS / IO_WS up to 15).
  localparam int WS_W = 4;

  // Ready-timeout counter width (TIMEOUT up to 255).
  localparam int TO_W = 8;

  // Channel index width (up to 16 I/O channels).
  localparam int CH_W = 4;

  // Pull an out-of-range TIMEOUT back into 1..255.
  function automatic int to_limit(input int t);
    if (t < 1) begin
      return 1;
    end
    if (t > 255) begin
      return 255;
    end
    return t;
  endfunction

endpackage

// File: rtl/wb_read_mux_iocs_prio_enc.sv
// Active-low chip-select priority encoder.
// Lowest selected channel wins; vld_o low when nothing is selected.
module iocs_prio_enc
  import wb_read_mux_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]  cs_n_i,
  output logic [CH_W-1:0] idx_o,
  output logic            vld_o
);

  // Scan from the top down so the lowest active select is written last.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (!cs_n_i[k]) begin
        idx_o = CH_W'(k);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_read_mux.sv
// Wishbone read-data mux: memory or one of NCH I/O channels, wait states,
// device ready, registered data with one-cycle ack. Option: WB_RD_TIMEOUT_EN.
module wb_read_mux
  import wb_read_mux_pkg::*;
#(
  parameter int DW      = 16,
  parameter int NCH     = 4,
  parameter int MEM_WS  = 0,
  parameter int IO_WS   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic              wb_tga_i,
  input  logic [DW-1:0]     mem_dat_i,
  input  logic [NCH-1:0]    iocs_n_i,
  input  logic [NCH*DW-1:0] io_dat_i,
  input  logic [NCH-1:0]    io_rdy_i,
  output logic              rdn_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o
);

  localparam logic [WS_W-1:0] MEM_LD = WS_W'(MEM_WS);
  localparam logic [WS_W-1:0] IO_LD  = WS_W'(IO_WS);
  localparam int              TO_LIM = to_limit(TIMEOUT);

  state_e          state_q, state_d;
  logic [WS_W-1:0] ws_q, ws_d;
  logic            tga_q, tga_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            nul_q, nul_d;
  logic            rdn_q, rdn_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic            ack_q, ack_d;

`ifdef WB_RD_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
`else
  logic            unused_to;
`endif

  logic [CH_W-1:0] enc_idx;
  logic            enc_vld;
  logic [DW-1:0]   io_sel_dat;
  logic            io_sel_rdy;
  logic            rd_req;

  iocs_prio_enc #(
    .NCH (NCH)
  ) u_enc (
    .cs_n_i (iocs_n_i),
    .idx_o  (enc_idx),
    .vld_o  (enc_vld)
  );

  assign rd_req = wb_cyc_i & wb_stb_i & ~wb_we_i;

  // Route the latched channel's data and ready; later chip-select
  // changes cannot redirect an in-flight read.
  always_comb begin
    io_sel_dat = '0;
    io_sel_rdy = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CH_W'(k)) begin
        io_sel_dat = io_dat_i[k*DW +: DW];
        io_sel_rdy = io_rdy_i[k];
      end
    end
  end

  // Next-state, counter and output decode for the read sequence.
  always_comb begin
    state_d = state_q;
    ws_d    = ws_q;
    tga_d   = tga_q;
    ch_d    = ch_q;
    nul_d   = nul_q;
    dat_d   = '0;
    ack_d   = 1'b0;
`ifdef WB_RD_TIMEOUT_EN
    to_d    = to_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          state_d = ST_WAIT;
          tga_d   = wb_tga_i;
          ch_d    = enc_idx;
          nul_d   = wb_tga_i & ~enc_vld;
          ws_d    = wb_tga_i ? IO_LD : MEM_LD;
`ifdef WB_RD_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (ws_q != '0) begin
          ws_d = ws_q - WS_W'(1);
        end else if (!tga_q) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          dat_d   = mem_dat_i;
        end else if (nul_q) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else if (io_sel_rdy) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          dat_d   = io_sel_dat;
        end
`ifdef WB_RD_TIMEOUT_EN
        else if (to_q == TO_W'(TO_LIM - 1)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
`endif
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Read strobe is low exactly while a read is waiting on its source.
    rdn_d = (state_d != ST_WAIT);
  end

  // Sequence state and registered bus outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ws_q    <= '0;
      tga_q   <= 1'b0;
      ch_q    <= '0;
      nul_q   <= 1'b0;
      rdn_q   <= 1'b1;
      dat_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      tga_q   <= tga_d;
      ch_q    <= ch_d;
      nul_q   <= nul_d;
      rdn_q   <= rdn_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
    end
  end

`ifdef WB_RD_TIMEOUT_EN
  // Ready-timeout counter and error pulse.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign wb_err_o = err_q;
`else
  assign unused_to = ^TO_LIM;
  assign wb_err_o  = 1'b0;
`endif

  assign rdn_o    = rdn_q;
  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;

endmodule
